// File: rtl/enum_sequencer.sv
// enum_sequencer: registered FSM stepping an enum code in toggle/up/down/pingpong modes.
// Optional auto-step dwell timer enabled by defining ENUM_SEQ_AUTO_STEP_EN.
module enum_sequencer #(
    parameter int WIDTH        = 8,
    parameter int NUM_VALUES   = 4,
    parameter int DWELL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             advance,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             wrap,
    output logic             fsm_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_TOGGLE = 2'd0,
        M_UP     = 2'd1,
        M_DOWN   = 2'd2,
        M_PING   = 2'd3
    } mode_t;

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(NUM_VALUES - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO = '0;

    state_t         state;
    logic           dir_up;
    logic           step;
    logic [WIDTH:0] cur;
    logic [WIDTH:0] nxt;
    logic           nxt_wrap;
    logic           nxt_dir_up;
    logic           going_up;
    logic           unused_msb;

    assign fsm_state  = state;
    assign unused_msb = nxt[WIDTH];

`ifdef ENUM_SEQ_AUTO_STEP_EN
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [DW-1:0] dwell;
    logic          tick;

    assign tick = (state == ST_RUN) && (dwell == DW'(DWELL_CYCLES - 1));
    assign step = (state == ST_RUN) && (advance || tick);

    always_ff @(posedge clk) begin
        if (reset || state != ST_RUN || stop || step) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (DWELL_CYCLES > 0);
    assign step       = (state == ST_RUN) && advance;
`endif

    always_comb begin
        cur        = {1'b0, value};
        nxt        = cur;
        nxt_wrap   = 1'b0;
        nxt_dir_up = dir_up;
        going_up   = 1'b0;
        unique case (mode_t'(mode))
            M_TOGGLE: begin
                if (cur == ZERO) begin
                    nxt = ONE;
                end else begin
                    nxt      = ZERO;
                    nxt_wrap = 1'b1;
                end
            end
            M_UP: begin
                if (cur >= LAST) begin
                    nxt      = ZERO;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt = cur + ONE;
                end
            end
            M_DOWN: begin
                if (cur == ZERO) begin
                    nxt      = LAST;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt = cur - ONE;
                end
            end
            M_PING: begin
                // Bounce off an endpoint even if another mode parked us there.
                going_up = (dir_up && cur < LAST) || (!dir_up && cur == ZERO);
                nxt      = going_up ? cur + ONE : cur - ONE;
                if (nxt == LAST) begin
                    nxt_dir_up = 1'b0;
                    nxt_wrap   = 1'b1;
                end else if (nxt == ZERO) begin
                    nxt_dir_up = 1'b1;
                    nxt_wrap   = 1'b1;
                end else begin
                    nxt_dir_up = going_up;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            value       <= '0;
            value_valid <= 1'b0;
            wrap        <= 1'b0;
            dir_up      <= 1'b1;
        end else begin
            unique case (state)
                ST_INIT: begin
                    wrap  <= 1'b0;
                    value <= '0;
                    if (start) begin
                        state       <= ST_RUN;
                        value_valid <= 1'b1;
                        dir_up      <= 1'b1;
                        if (mode_t'(mode) == M_DOWN) begin
                            value <= LAST[WIDTH-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state       <= ST_INIT;
                        value       <= '0;
                        value_valid <= 1'b0;
                        wrap        <= 1'b0;
                    end else if (step) begin
                        value  <= nxt[WIDTH-1:0];
                        wrap   <= nxt_wrap;
                        dir_up <= nxt_dir_up;
                    end else begin
                        wrap <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enum_sequencer.sv
// Scoreboard bench for enum_sequencer: integer reference model feeds an
// expected-output queue drained by an independent monitor.
module tb_enum_sequencer;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 3;
`ifdef ENUM_SEQ_AUTO_STEP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] v;
        logic         vld;
        logic         wr;
        logic         st;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         advance = 1'b0;
    logic [W-1:0] value;
    logic         value_valid;
    logic         wrap;
    logic         fsm_state;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t sbq[$];

    // reference model state
    bit m_run = 0;
    int m_v   = 0;
    bit m_w   = 0;
    int m_dir = 1;
    int m_cnt = 0;

    enum_sequencer #(
        .WIDTH(W),
        .NUM_VALUES(N),
        .DWELL_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .mode(mode),
        .advance(advance),
        .value(value),
        .value_valid(value_valid),
        .wrap(wrap),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic model(input bit r, input bit s, input bit p,
                         input int m, input bit a);
        bit tick;
        if (r) begin
            m_run = 0; m_v = 0; m_w = 0; m_dir = 1; m_cnt = 0;
        end else if (!m_run) begin
            m_w = 0; m_v = 0; m_cnt = 0;
            if (s) begin
                m_run = 1;
                m_dir = 1;
                m_v   = (m == 2) ? N - 1 : 0;
            end
        end else if (p) begin
            m_run = 0; m_v = 0; m_w = 0; m_cnt = 0;
        end else begin
            tick = AUTO && (m_cnt == D - 1);
            m_w  = 0;
            if (a || tick) begin
                m_cnt = 0;
                case (m)
                    0: begin
                        if (m_v == 0) m_v = 1;
                        else begin m_v = 0; m_w = 1; end
                    end
                    1: begin
                        m_v = (m_v + 1) % N;
                        m_w = (m_v == 0);
                    end
                    2: begin
                        m_v = (m_v + N - 1) % N;
                        m_w = (m_v == N - 1);
                    end
                    default: begin
                        if (m_v + m_dir < 0 || m_v + m_dir > N - 1) m_dir = -m_dir;
                        m_v = m_v + m_dir;
                        if (m_v == 0) begin m_w = 1; m_dir = 1; end
                        else if (m_v == N - 1) begin m_w = 1; m_dir = -1; end
                    end
                endcase
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p,
                       input int m, input bit a);
        obs_t e;
        @(negedge clk);
        reset   = r;
        start   = s;
        stop    = p;
        mode    = 2'(m);
        advance = a;
        model(r, s, p, m, a);
        e.v   = W'(m_v);
        e.vld = m_run;
        e.wr  = m_w;
        e.st  = m_run;
        sbq.push_back(e);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                got = {value, value_valid, wrap, fsm_state};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got v=%0d vld=%b wrap=%b st=%b, expected v=%0d vld=%b wrap=%b st=%b",
                             $time, got.v, got.vld, got.wr, got.st,
                             e.v, e.vld, e.wr, e.st);
                end
            end
        end
    end

    initial begin : stim
        // reset held with start high
        repeat (3) cyc(1, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 0);
        // UP, advance held five cycles
        repeat (5) cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 1, 1, 0);
        // PINGPONG, advance held seven cycles
        cyc(0, 1, 0, 3, 0);
        repeat (7) cyc(0, 0, 0, 3, 1);
        // UP to 3, then TOGGLE twice
        repeat (2) cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // reach 2 then stop with advance
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // reset mid-run at value 2
        cyc(0, 1, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        // start in DOWN mode, step down, start+stop priority
        cyc(0, 1, 1, 2, 0);
        repeat (3) cyc(0, 0, 0, 2, 1);
        cyc(0, 1, 1, 2, 1);
        // idle run in UP (exercises auto-step when built)
        cyc(0, 1, 0, 1, 0);
        repeat (10) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 23) == 0),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0));
        end
        cyc(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enum_sequencer.md
# enum_sequencer

Parametrised enum-state sequencer: a registered FSM that, once started, steps an enumerated output code through a configurable value set in one of four modes (toggle, count up, count down, ping-pong). It generalises the single-bit 0/1 toggling enum block to arbitrary width and value count, adds run control and a wrap indication, and serves as a reusable state/enum stimulus source for unit tests and small control paths.

## Interface
- WIDTH, 8: width of the enum code on `value`; 1..32.
- NUM_VALUES, 4: size of the enum set {0..NUM_VALUES-1}; 2..2^WIDTH.
- DWELL_CYCLES, 3: cycles per auto-step; ≥1; used only with the auto-step macro.

- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; overrides every other input.
- start  input  1  INITIAL→RUN request; ignored while in RUN.
- stop  input  1  RUN→INITIAL request.
- mode  input  2  0 TOGGLE, 1 UP, 2 DOWN, 3 PINGPONG; sampled on every step.
- advance  input  1  step request, one step per cycle high while in RUN.
- value  output  WIDTH  current enum code, registered.
- value_valid  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when the step just taken wrapped or turned around.
- fsm_state  output  1  0 INITIAL, 1 RUN.

## Operation
- Reset values: value=0, value_valid=0, wrap=0, fsm_state=INITIAL, direction=up, dwell counter=0.
- INITIAL: value held at 0, value_valid=0. start=1 → RUN next edge, value_valid=1, value=0 (DOWN mode: value=NUM_VALUES-1), direction=up.
- RUN: a step occurs on a cycle with advance=1 (or auto-step tick, see Configuration). Next value per mode:
  - TOGGLE: 0→1, any nonzero→0. wrap=1 on each 1→0 transition (and on nonzero→0).
  - UP: v+1; at NUM_VALUES-1 → 0, wrap=1.
  - DOWN: v-1; at 0 → NUM_VALUES-1, wrap=1.
  - PINGPONG: move in direction; reaching NUM_VALUES-1 flips direction to down, reaching 0 flips to up; wrap=1 on the step that lands on an endpoint. Direction kept across mode changes.
- Mode change mid-run: takes effect on the next step, from the current value; no value jump without a step.
- Arithmetic done in WIDTH+1 bits; value never leaves 0..NUM_VALUES-1.
- stop=1 in RUN → INITIAL next edge, value=0, value_valid=0, wrap=0; any same-cycle advance is discarded.
- start and stop both high in INITIAL → start wins (stop has no meaning there). Both high in RUN → stop wins.
- reset mid-run: all registers return to reset values on that edge, regardless of other inputs.

## Timing
- All outputs registered; no combinational input→output path.
- advance at cycle n → new value and wrap visible after edge n (latency 1); wrap deasserts the following cycle unless another wrapping step occurs.
- start at cycle n → value_valid=1 after edge n; first step no earlier than the cycle after.
- Back-to-back advance: one step per cycle, full throughput.

## Configuration
- ENUM_SEQ_AUTO_STEP_EN defined: a dwell counter runs while in RUN, producing an internal step tick every DWELL_CYCLES cycles (first tick DWELL_CYCLES cycles after entering RUN); step = advance OR tick, still at most one step per cycle; counter clears on any step, on stop and on reset.
- Not defined: no counter is built; DWELL_CYCLES ignored; only advance steps the sequence.

## Test plan
- Reset with start held high → value=0, value_valid=0, fsm_state=0 throughout; after reset drops, start → value_valid=1, value=0 next cycle.
- UP, NUM_VALUES=4, advance held 5 cycles → value 1,2,3,0,1; wrap=1 only on the cycle value=0.
- PINGPONG, NUM_VALUES=4, advance held 7 cycles → 1,2,3,2,1,0,1; wrap on values 3 and 0.
- TOGGLE after UP has reached value=3, one advance → value=0, wrap=1; next advance → 1, wrap=0.
- stop and advance same cycle at value=2 → next cycle value=0, value_valid=0, wrap=0, fsm_state=0; reset asserted mid-run gives identical result.
- With ENUM_SEQ_AUTO_STEP_EN, DWELL_CYCLES=3, UP, advance=0 → value increments every 3rd cycle after start: 0,0,0,1,1,1,2…
